line_buffer_array: RTL
======================

Name: line_buffer_array

Overview:
- Parametrised multi-row line buffer for the 3x3 and NxN window pipeline.
- Takes a raster pixel stream and presents NUM_LINES+1 vertically aligned taps: the current pixel plus the same column from each of the previous NUM_LINES rows.
- Uses internal inferred RAM instead of a vendor FIFO IP.
- Adds frame-start resynchronisation, stall tolerance and a fill-level indicator.

Parameters:
- WIDTH, 10, pixel data width in bits.
- IMG_WIDTH, 480, pixels per row; must be >= 2.
- NUM_LINES, 2, number of stored rows (output taps = NUM_LINES+1); must be >= 1.
- CW, $clog2(IMG_WIDTH), column counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input pixel.
- valid_in  input  1  din valid; each high cycle consumes one pixel.
- sof  input  1  start of frame; qualified by valid_in; marks din as row 0, column 0.
- dout  output  (NUM_LINES+1)*WIDTH  taps; slice k (bits k*WIDTH +: WIDTH) is the pixel k rows above the current pixel. Slice 0 is the current pixel.
- valid_out  output  1  dout valid.
- col_out  output  CW  column index of the pixel on dout.
- fill  output  $clog2(NUM_LINES+1)  rows completed in this frame, saturating at NUM_LINES.

Behaviour:
- Reset (async, rst_n low):
  - col=0, fill=0, dout=0, valid_out=0, col_out=0.
  - RAM contents are not cleared.
  - Reset may occur mid-frame; after release, output is suppressed until a sof pixel arrives.
- Storage: NUM_LINES RAMs, each IMG_WIDTH x WIDTH, chained.
  - On an accepted pixel at column c, RAM k is read at c (old content) and written at c with the value RAM k-1 held before this write (RAM 0 is written with din).
  - Read-before-write at the same address is mandatory.
- Column counter:
  - Increments on each valid_in.
  - Wraps from IMG_WIDTH-1 to 0.
  - At each wrap, fill increments, saturating at NUM_LINES.
- sof with valid_in: that pixel is forced to column 0; fill is cleared to 0; the frame-armed flag is set. sof without valid_in is ignored.
- Latency: exactly 1 cycle, valid_in to valid_out. dout and col_out are registered together with valid_out.
- valid_out = (registered valid_in) AND armed AND (fill == NUM_LINES at acceptance time).
- When valid_out is low, dout holds its last value.
- Stall: valid_in low leaves all state unchanged. Gaps of any length, including inside a row, must not disturb alignment.
- Row length mismatch: a sof arriving before column IMG_WIDTH-1 truncates the row. Stored data for the unwritten columns is stale; valid_out stays low until NUM_LINES new rows have filled.
- Pixel throughput: one pixel per clock sustained, with no bubbles.

Optional Feature:
- Macro: LINE_BUFFER_ARRAY_BORDER_REPLICATE_EN.
- Defined:
  - Top-border replication. While fill < NUM_LINES, any tap k > fill outputs the tap at index fill (the oldest real row).
  - valid_out asserts from the first armed pixel of the frame (row 0).
  - The output row count equals the input row count.
- Undefined:
  - valid_out suppressed until fill == NUM_LINES, as above.
  - Output rows = input rows - NUM_LINES.
  - No extra muxing is synthesised.

Test Plan (IMG_WIDTH=4, NUM_LINES=2, WIDTH=10, pixel = row*16+col):
1. Reset, then sof plus a continuous 4x4 frame -> valid_out low for the first 8 pixels. First valid_out occurs 1 cycle after pixel (2,0), with taps {0x00,0x10,0x20} (slice2..slice0) and col_out=0. 8 valid outputs total.
2. Same frame with valid_in toggling 1,0,0,1 randomly -> identical output sequence to scenario 1. valid_out pulses are exactly 1 cycle after each accepted pixel.
3. Second frame (pixel = 0x100+row*16+col) with sof immediately after frame 1 -> fill returns to 0. No valid_out for its first 8 pixels; no frame-1 data appears on taps when valid.
4. rst_n asserted during row 2 column 1, released, stream resumed without sof -> valid_out stays 0. After a subsequent sof frame, behaviour matches scenario 1.
5. sof at column 2 of row 1 (truncated row) -> fill=0, col restarts at 0. The first valid output is at new row 2, column 0.
6. With LINE_BUFFER_ARRAY_BORDER_REPLICATE_EN: scenario 1 stimulus ->
   - valid_out on all 16 pixels.
   - Pixel (0,1) gives taps {0x01,0x01,0x01}.
   - Pixel (1,3) gives {0x03,0x03,0x13}.

Source files
------------

// File: rtl/line_buffer_array.sv
// Multi-row line buffer: presents the current pixel plus the same column from the
// previous NUM_LINES rows. Optional top-border replication: LINE_BUFFER_ARRAY_BORDER_REPLICATE_EN.
`timescale 1ns/1ps
module line_buffer_array #(
    parameter int WIDTH     = 10,
    parameter int IMG_WIDTH = 480,
    parameter int NUM_LINES = 2,
    parameter int CW        = $clog2(IMG_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH-1:0]                 din,
    input  logic                             valid_in,
    input  logic                             sof,
    output logic [(NUM_LINES+1)*WIDTH-1:0]   dout,
    output logic                             valid_out,
    output logic [CW-1:0]                    col_out,
    output logic [$clog2(NUM_LINES+1)-1:0]   fill
);

    localparam int              FW        = $clog2(NUM_LINES+1);
    localparam logic [CW-1:0]   COL_LAST  = CW'(IMG_WIDTH-1);
    localparam logic [FW-1:0]   FILL_FULL = FW'(NUM_LINES);

    logic [CW-1:0]                       col_q, col_d;
    logic [FW-1:0]                       fill_q, fill_d;
    logic                                armed_q, armed_d;
    logic [NUM_LINES:0][WIDTH-1:0]       dout_q, dout_d;
    logic                                valid_out_q, valid_out_d;
    logic [CW-1:0]                       col_out_q, col_out_d;

    // Effective state for the pixel on the input this cycle (sof restarts the frame).
    logic [CW-1:0]                       col_acc;
    logic [FW-1:0]                       fill_acc;
    logic                                armed_acc;

    logic [NUM_LINES:0][WIDTH-1:0]       tap;
    logic [NUM_LINES:0][WIDTH-1:0]       sel_tap;
    logic                                col_wrap;

    assign col_acc   = sof ? '0 : col_q;
    assign fill_acc  = sof ? '0 : fill_q;
    assign armed_acc = armed_q | sof;
    assign col_wrap  = (col_acc == COL_LAST);

    assign tap[0] = din;

    // Each line RAM shifts the old content of the previous one in at the same
    // column; the read happens before the write lands, so taps see last row's data.
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        logic [WIDTH-1:0] line_mem [IMG_WIDTH];

        assign tap[gi+1] = line_mem[col_acc];

        always_ff @(posedge clk) begin
            if (valid_in) begin
                line_mem[col_acc] <= tap[gi];
            end
        end
    end

`ifdef LINE_BUFFER_ARRAY_BORDER_REPLICATE_EN
    // Rows above the top of the frame repeat the oldest real row.
    always_comb begin
        sel_tap = tap;
        for (int k = 0; k <= NUM_LINES; k++) begin
            if (FW'(k) > fill_acc) begin
                sel_tap[k] = tap[fill_acc];
            end
        end
    end
`else
    assign sel_tap = tap;
`endif

    always_comb begin
        col_d       = col_q;
        fill_d      = fill_q;
        armed_d     = armed_q;
        valid_out_d = 1'b0;
        dout_d      = dout_q;
        col_out_d   = col_out_q;

        if (valid_in) begin
            armed_d = armed_acc;
            col_d   = col_wrap ? '0 : col_acc + 1'b1;
            fill_d  = fill_acc;
            if (col_wrap && (fill_acc != FILL_FULL)) begin
                fill_d = fill_acc + 1'b1;
            end
`ifdef LINE_BUFFER_ARRAY_BORDER_REPLICATE_EN
            valid_out_d = armed_acc;
`else
            valid_out_d = armed_acc && (fill_acc == FILL_FULL);
`endif
            if (valid_out_d) begin
                dout_d    = sel_tap;
                col_out_d = col_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            col_out_q   <= '0;
        end else begin
            col_q       <= col_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            dout_q      <= dout_d;
            valid_out_q <= valid_out_d;
            col_out_q   <= col_out_d;
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_out_q;
    assign col_out   = col_out_q;
    assign fill      = fill_q;

endmodule
